// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and FSM state encoding for the CNN frame loader.
//   NPIX_DEF  - pixels per frame (8x8 image)
//   PIX_W_DEF - pixel width
//   RES_W_DEF - core result width
//   state_t   - loader FSM states
package cnn_pkg;
    localparam int NPIX_DEF  = 64;
    localparam int PIX_W_DEF = 8;
    localparam int RES_W_DEF = 16;
    typedef enum logic [1:0] {FILL, RUN, OUT, CLEAR} state_t;
endpackage

// File: rtl/cnn_watchdog.sv
// cnn_watchdog: cycle counter that flags when the core has run TIMEOUT cycles.
//   clk, rst - clock, synchronous active-high reset
//   clear    - force the count back to 0
//   enable   - count one cycle
//   expired  - count has reached TIMEOUT-1
module cnn_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT) + 1;
    logic [W-1:0] count;
    assign expired = count == W'(TIMEOUT - 1);
    // Saturate at the limit so a stalled FSM cannot wrap the count.
    always_ff @(posedge clk)
        if (rst || clear) count <= '0;
        else if (enable && !expired) count <= count + 1'b1;
endmodule

// File: rtl/img_frame_loader.sv
// img_frame_loader: buffers a raster pixel stream into a frame, runs the CNN core, returns its result.
//   clk, rst                         - clock, synchronous active-high reset
//   s_valid/s_ready/s_data/s_last    - pixel stream in
//   core_img/core_enable/core_clear  - frame and control to the CNN core
//   core_done/core_value             - core completion and result
//   m_valid/m_ready/m_data           - result stream out
//   err_frame/err_timeout            - one-cycle error pulses
//   busy                             - loader is mid-frame or not idle
module img_frame_loader
    import cnn_pkg::*;
#(
    parameter int NPIX    = NPIX_DEF,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [PIX_W-1:0]      s_data,
    input  logic                  s_last,
    output logic [NPIX*PIX_W-1:0] core_img,
    output logic                  core_enable,
    output logic                  core_clear,
    input  logic                  core_done,
    input  logic [RES_W-1:0]      core_value,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RES_W-1:0]      m_data,
    output logic                  err_frame,
    output logic                  err_timeout,
    output logic                  busy
);
    localparam int CW = $clog2(NPIX);
    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          beat, at_end, expired;
    assign beat        = s_valid && s_ready;
    assign at_end      = cnt == CW'(NPIX - 1);
    // Held low while rst is asserted so every output reads 0 during reset.
    assign s_ready     = state == FILL && !rst;
    assign core_enable = state == RUN;
    assign core_clear  = state == CLEAR;
    assign m_valid     = state == OUT;
    assign busy        = state != FILL || cnt != '0;
    cnn_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != RUN),
        .enable (state == RUN),
        .expired(expired)
    );
    always_ff @(posedge clk)
        if (rst) state <= FILL;
        else state <= state_n;
    // core_done is checked before the watchdog so a same-cycle finish still yields a result.
    always_comb begin
        state_n = state;
        case (state)
            FILL:    state_n = beat && s_last && at_end ? RUN : FILL;
            RUN:     state_n = core_done ? OUT : expired ? CLEAR : RUN;
            OUT:     state_n = m_ready ? CLEAR : OUT;
            default: state_n = FILL;
        endcase
    end
    always_ff @(posedge clk)
        if (rst) begin
            cnt         <= '0;
            core_img    <= '0;
            m_data      <= '0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_frame   <= beat && (s_last != at_end);
            err_timeout <= state == RUN && !core_done && expired;
            if (beat) begin
                core_img[int'(cnt)*PIX_W +: PIX_W] <= s_data;
                cnt <= s_last || at_end ? '0 : cnt + 1'b1;
            end
            if (state == RUN && core_done) m_data <= core_value;
        end
endmodule

// File: tb/tb_img_frame_loader.sv
// tb_img_frame_loader: directed scoreboard bench for img_frame_loader.
module tb_img_frame_loader;
    localparam int NPIX = 64, PIX_W = 8, RES_W = 16, TIMEOUT = 4096;
    logic                  clk = 0, rst = 1;
    logic                  s_valid = 0, s_last = 0, core_done = 0, m_ready = 0;
    logic [PIX_W-1:0]      s_data = '0;
    logic [RES_W-1:0]      core_value = '0;
    logic                  s_ready, core_enable, core_clear, m_valid, err_frame, err_timeout, busy;
    logic [NPIX*PIX_W-1:0] core_img, img_exp, img_hold;
    logic [RES_W-1:0]      m_data, m_hold;
    logic [RES_W-1:0]      sb[$];
    int vectors = 0, miscompares = 0, n;

    img_frame_loader #(.NPIX(NPIX), .PIX_W(PIX_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .core_img(core_img), .core_enable(core_enable), .core_clear(core_clear),
        .core_done(core_done), .core_value(core_value), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .err_frame(err_frame), .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NPIX*PIX_W-1:0] obs, input logic [NPIX*PIX_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Streams n beats; pixel i = i*mul+add; s_last on beat last_at (-1 for none).
    task automatic send_frame(input int cnt, input int last_at, input int mul, input int add);
        for (int i = 0; i < cnt; i++) begin
            s_valid = 1;
            s_data  = PIX_W'(i * mul + add);
            s_last  = i == last_at;
            tick();
        end
        s_valid = 0;
        s_last  = 0;
    endtask

    task automatic build_img(input int mul, input int add);
        for (int i = 0; i < NPIX; i++) img_exp[i*PIX_W +: PIX_W] = PIX_W'(i * mul + add);
    endtask

    task automatic take_result(input string tag);
        logic [RES_W-1:0] exp;
        n = 0;
        while (!m_valid && n < 50) begin tick(); n++; end
        chk({tag, "_mvalid"}, m_valid, 1'b1);
        exp = sb.size() > 0 ? sb.pop_front() : 'x;
        chk({tag, "_mdata"}, m_data, exp);
    endtask

    task automatic handshake(input string tag);
        m_ready = 1;
        tick();
        m_ready = 0;
        chk({tag, "_clear"}, core_clear, 1'b1);
        chk({tag, "_sready_clear"}, s_ready, 1'b0);
        tick();
        chk({tag, "_clear_done"}, core_clear, 1'b0);
        chk({tag, "_sready_back"}, s_ready, 1'b1);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_sready", s_ready, 1'b0);
        chk("rst_outs", {core_enable, core_clear, m_valid, err_frame, err_timeout, busy}, 6'b0);
        chk("rst_mdata", m_data, '0);
        chk("rst_img", core_img, '0);
        rst = 0;
        #1;
        chk("post_rst_sready", s_ready, 1'b1);

        // Normal frame, core finishes after 10 cycles
        send_frame(64, 63, 1, 0);
        build_img(1, 0);
        chk("a_enable", core_enable, 1'b1);
        chk("a_sready_run", s_ready, 1'b0);
        chk("a_img", core_img, img_exp);
        repeat (10) tick();
        core_done = 1; core_value = 16'h1234; sb.push_back(16'h1234);
        tick();
        core_done = 0;
        chk("a_enable_off", core_enable, 1'b0);
        take_result("a");
        handshake("a");

        // Early s_last discards the frame, next frame runs normally
        send_frame(21, 20, 3, 100);
        chk("b_err_frame", err_frame, 1'b1);
        chk("b_no_enable", core_enable, 1'b0);
        chk("b_idle", busy, 1'b0);
        tick();
        chk("b_err_pulse", err_frame, 1'b0);
        send_frame(64, 63, 5, 7);
        build_img(5, 7);
        chk("b_img", core_img, img_exp);
        core_done = 1; core_value = 16'hBEEF; sb.push_back(16'hBEEF);
        tick();
        core_done = 0;
        take_result("b");
        handshake("b");

        // 64 pixels without s_last
        send_frame(64, -1, 1, 1);
        chk("c_err_frame", err_frame, 1'b1);
        chk("c_idle", busy, 1'b0);
        chk("c_fill", {s_ready, core_enable}, 2'b10);

        // Timeout: core never finishes
        tick();
        send_frame(64, 63, 2, 0);
        n = 0;
        do begin tick(); n++; end while (!err_timeout && n < TIMEOUT + 8);
        chk("d_latency", n, TIMEOUT);
        chk("d_clear", core_clear, 1'b1);
        chk("d_no_result", m_valid, 1'b0);
        chk("d_mdata_hold", m_data, 16'hBEEF);
        tick();
        chk("d_err_pulse", err_timeout, 1'b0);
        chk("d_sready", s_ready, 1'b1);

        // core_done on the watchdog limit wins
        send_frame(64, 63, 1, 9);
        repeat (TIMEOUT - 1) tick();
        core_done = 1; core_value = 16'h0F0F; sb.push_back(16'h0F0F);
        tick();
        core_done = 0;
        chk("e_no_timeout", err_timeout, 1'b0);
        take_result("e");
        handshake("e");

        // s_valid toggling in RUN is ignored; 50 cycles of backpressure
        send_frame(64, 63, 7, 3);
        build_img(7, 3);
        for (int i = 0; i < 6; i++) begin
            s_valid = i[0]; s_data = 8'hEE; s_last = 1;
            tick();
            chk("f_sready_run", s_ready, 1'b0);
        end
        s_valid = 0; s_last = 0;
        chk("f_img_stable", core_img, img_exp);
        chk("f_no_err", err_frame, 1'b0);
        core_done = 1; core_value = 16'h8001; sb.push_back(16'h8001);
        tick();
        core_done = 0; core_value = 16'h7777;
        take_result("f");
        m_hold = m_data;
        for (int i = 0; i < 50; i++) begin
            s_valid = i[0];
            tick();
            chk("f_hold_valid", m_valid, 1'b1);
            chk("f_hold_data", m_data, 16'h8001);
            chk("f_hold_sready", s_ready, 1'b0);
        end
        s_valid = 0;
        chk("f_hold_total", m_data, m_hold);
        handshake("f");

        // Reset mid-RUN, then a clean frame
        send_frame(64, 63, 1, 0);
        repeat (3) tick();
        rst = 1;
        tick();
        chk("g_outs", {s_ready, core_enable, core_clear, m_valid, err_frame, err_timeout, busy}, 7'b0);
        chk("g_mdata", m_data, '0);
        chk("g_img", core_img, '0);
        rst = 0;
        #1;
        chk("g_sready", s_ready, 1'b1);
        img_hold = '0;
        send_frame(64, 63, 11, 2);
        build_img(11, 2);
        chk("g_img_new", core_img, img_exp);
        chk("g_enable", core_enable, 1'b1);
        repeat (5) tick();
        core_done = 1; core_value = 16'h00FF; sb.push_back(16'h00FF);
        tick();
        core_done = 0;
        take_result("g");
        handshake("g");
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/img_frame_loader.md
IMG_FRAME_LOADER -- requirements
Module: img_frame_loader

Interface
REQ-001 Parameters (name, default, meaning):
- NPIX, 64, pixels per frame (8x8 image).
- PIX_W, 8, pixel width.
- RES_W, 16, core result width.
- TIMEOUT, 4096, maximum cycles the core may stay in RUN.
REQ-002 clk  in  1  clock; all logic on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 s_valid  in  1  input pixel valid.
REQ-005 s_ready  out  1  loader accepts a pixel.
REQ-006 s_data  in  PIX_W  pixel value, raster order.
REQ-007 s_last  in  1  marks the final pixel of a frame.
REQ-008 core_img  out  NPIX*PIX_W  flattened frame; pixel i occupies bits [i*PIX_W+PIX_W-1 : i*PIX_W].
REQ-009 core_enable  out  1  level enable to the CNN core.
REQ-010 core_clear  out  1  one-cycle clear pulse to the CNN core.
REQ-011 core_done  in  1  core finished; held high by the core.
REQ-012 core_value  in  RES_W  core result, valid while core_done=1.
REQ-013 m_valid  out  1  result valid.
REQ-014 m_ready  in  1  downstream accepts the result.
REQ-015 m_data  out  RES_W  captured result.
REQ-016 err_frame  out  1  one-cycle pulse on framing error.
REQ-017 err_timeout  out  1  one-cycle pulse on core timeout.
REQ-018 busy  out  1  high when state!=FILL or pixel count!=0.

Function
REQ-019 The FSM SHALL have states FILL, RUN, OUT and CLEAR; all outputs are registered or decoded from state only.
REQ-020 FILL: s_ready=1; each s_valid&s_ready beat writes s_data to pixel[cnt] and increments a 6-bit cnt.
REQ-021 A beat with cnt==NPIX-1 and s_last=1 SHALL reset cnt to 0 and enter RUN next cycle.
REQ-022 A beat with s_last=1 and cnt<NPIX-1, or with cnt==NPIX-1 and s_last=0, SHALL discard the frame:
- err_frame pulses next cycle.
- cnt returns to 0.
- the FSM stays in FILL.
REQ-023 s_ready SHALL be 0 in RUN, OUT and CLEAR; core_img SHALL be stable outside FILL.
REQ-024 RUN: core_enable=1 and the watchdog counts from 0. On core_done=1, core_value is captured into m_data and the FSM enters OUT.
REQ-025 RUN timeout: watchdog reaches TIMEOUT-1 with core_done=0 -> err_timeout pulses, m_data holds its old value, FSM enters CLEAR without producing a result.
REQ-026 If core_done=1 and the watchdog reaches TIMEOUT-1 in the same cycle, core_done SHALL win (no err_timeout).
REQ-027 OUT: m_valid=1 and m_data stays stable until m_valid&m_ready; that handshake moves the FSM to CLEAR.
REQ-028 CLEAR: core_clear=1 and core_enable=0 for exactly one cycle, then the FSM returns to FILL.
REQ-029 Latencies:
- last pixel beat at cycle t -> core_enable=1 at t+1.
- core_done sampled at cycle d -> m_valid=1 at d+1, core_enable=0 at d+1.
- m_ready handshake at cycle r -> core_clear=1 at r+1, s_ready=1 at r+2.
REQ-030 m_data SHALL equal core_value bit-for-bit, with no sign or width conversion.

Reset
REQ-031 On rst: state=FILL, cnt=0, watchdog=0, pixel buffer=0, m_data=0, and all outputs 0. s_ready=1 from the first cycle after rst deasserts.
REQ-032 rst mid-RUN or mid-OUT SHALL abandon the frame with no core_clear pulse; the core shares rst.

Structure
REQ-033 Shared package cnn_pkg SHALL hold NPIX, PIX_W and RES_W defaults plus the FSM state encoding.
REQ-034 The watchdog SHALL be a sub-module cnn_watchdog (clear, enable, expired) with width clog2(TIMEOUT)+1; the rest is flat.

Verification
REQ-035 Stream pixels 0..63 with s_last on pixel 63, core_done after 10 cycles with core_value=16'h1234 -> core_img pixel i==i, m_valid with m_data=16'h1234, then one core_clear pulse.
REQ-036 s_last on pixel 20 -> err_frame pulse, no core_enable; the next full frame is processed normally.
REQ-037 64 pixels with no s_last -> err_frame pulse, cnt=0, FSM stays in FILL.
REQ-038 core_done never asserted -> err_timeout exactly TIMEOUT cycles after entering RUN, then core_clear, then s_ready=1.
REQ-039 m_ready held low 50 cycles -> m_valid and m_data stable, s_ready=0 throughout; s_valid toggling during RUN is ignored.
REQ-040 rst asserted mid-RUN -> next cycle all outputs 0, followed by a clean 64-pixel frame accepted.
